// File: rtl/memgame_pkg.sv
// Shared types and constants for the memory game sequence controller.
package memgame_pkg;

  localparam int NUM_W         = 4;
  localparam int MAX_LEN_LIMIT = 16;

  typedef enum logic [2:0] {
    S_IDLE,
    S_ADD,
    S_SHOW,
    S_GAP,
    S_INPUT,
    S_WIN,
    S_FAIL
  } state_t;

  // Largest of three cycle counts; sizes the shared down-counter.
  function automatic int max3(input int a, input int b, input int c);
    int m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

// File: rtl/memgame_seq_mem.sv
// Sequence storage: one synchronous write port, one combinational read port.
// Contents are deliberately not reset; entries beyond the current length are never read.
module memgame_seq_mem
  import memgame_pkg::*;
#(
  parameter int DEPTH = MAX_LEN_LIMIT,
  parameter int AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic             clk,
  input  logic             wr_en,
  input  logic [AW-1:0]    wr_addr,
  input  logic [NUM_W-1:0] wr_data,
  input  logic [AW-1:0]    rd_addr,
  output logic [NUM_W-1:0] rd_data
);

  logic [NUM_W-1:0] mem [DEPTH];

  // Capture a new sequence element when the controller asks for it.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_addr] <= wr_data;
    end
  end

  assign rd_data = mem[rd_addr];

endmodule

// File: rtl/memgame_ctrl.sv
// Memory game sequence controller: grows a random sequence one element per
// round, plays it back on the display path and checks the player's entries.
// Optional build macro MEMGAME_TIMEOUT_EN adds an input timeout that fails
// the game when no entry arrives within TIMEOUT_CYCLES.
module memgame_ctrl
  import memgame_pkg::*;
#(
  parameter int MAX_LEN        = 16,
  parameter int SHOW_CYCLES    = 25_000_000,
  parameter int GAP_CYCLES     = 12_500_000,
  parameter int TIMEOUT_CYCLES = 250_000_000,
  localparam int LEN_W         = $clog2(MAX_LEN + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [NUM_W-1:0] rnd_in,
  input  logic             guess_valid,
  input  logic [NUM_W-1:0] guess,
  output logic             show_valid,
  output logic [NUM_W-1:0] show_num,
  output logic             awaiting_input,
  output logic [LEN_W-1:0] level,
  output logic             win,
  output logic             fail
);

  localparam int AW      = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;
  localparam int TMR_MAX = max3(SHOW_CYCLES, GAP_CYCLES, TIMEOUT_CYCLES);
  localparam int TMR_W   = $clog2(TMR_MAX + 1);

  localparam logic [TMR_W-1:0] SHOW_LOAD = TMR_W'(SHOW_CYCLES - 1);
  localparam logic [TMR_W-1:0] GAP_LOAD  = TMR_W'(GAP_CYCLES - 1);
`ifdef MEMGAME_TIMEOUT_EN
  localparam logic [TMR_W-1:0] INPUT_LOAD = TMR_W'(TIMEOUT_CYCLES - 1);
`else
  localparam logic [TMR_W-1:0] INPUT_LOAD = '0;
`endif

  state_t           state;
  logic [LEN_W-1:0] len;
  logic [LEN_W-1:0] idx;
  logic [LEN_W-1:0] len_m1;
  logic [TMR_W-1:0] timer;
  logic [NUM_W-1:0] rd_data;
  logic             last_idx;

  assign len_m1   = len - LEN_W'(1);
  assign last_idx = (idx == len_m1);
  assign level    = len;
  assign show_num = show_valid ? rd_data : '0;

  memgame_seq_mem #(
    .DEPTH (MAX_LEN),
    .AW    (AW)
  ) u_seq_mem (
    .clk     (clk),
    .wr_en   (state == S_ADD),
    .wr_addr (len[AW-1:0]),
    .wr_data (rnd_in),
    .rd_addr (idx[AW-1:0]),
    .rd_data (rd_data)
  );

  // Game FSM with its shared timer, length/index counters and registered status outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state          <= S_IDLE;
      len            <= '0;
      idx            <= '0;
      timer          <= '0;
      show_valid     <= 1'b0;
      awaiting_input <= 1'b0;
      win            <= 1'b0;
      fail           <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (start) begin
            len   <= '0;
            idx   <= '0;
            timer <= '0;
            state <= S_ADD;
          end
        end

        S_ADD: begin
          len        <= len + LEN_W'(1);
          idx        <= '0;
          timer      <= SHOW_LOAD;
          show_valid <= 1'b1;
          state      <= S_SHOW;
        end

        S_SHOW: begin
          if (timer == '0) begin
            show_valid <= 1'b0;
            timer      <= GAP_LOAD;
            state      <= S_GAP;
          end else begin
            timer <= timer - TMR_W'(1);
          end
        end

        S_GAP: begin
          if (timer == '0) begin
            if (last_idx) begin
              idx            <= '0;
              awaiting_input <= 1'b1;
              timer          <= INPUT_LOAD;
              state          <= S_INPUT;
            end else begin
              idx        <= idx + LEN_W'(1);
              show_valid <= 1'b1;
              timer      <= SHOW_LOAD;
              state      <= S_SHOW;
            end
          end else begin
            timer <= timer - TMR_W'(1);
          end
        end

        S_INPUT: begin
          if (guess_valid) begin
            if (guess != rd_data) begin
              fail           <= 1'b1;
              awaiting_input <= 1'b0;
              timer          <= '0;
              state          <= S_FAIL;
            end else if (!last_idx) begin
              idx   <= idx + LEN_W'(1);
              timer <= INPUT_LOAD;
            end else if (len == LEN_W'(MAX_LEN)) begin
              win            <= 1'b1;
              awaiting_input <= 1'b0;
              timer          <= '0;
              state          <= S_WIN;
            end else begin
              awaiting_input <= 1'b0;
              timer          <= '0;
              state          <= S_ADD;
            end
          end
`ifdef MEMGAME_TIMEOUT_EN
          else if (timer == '0) begin
            fail           <= 1'b1;
            awaiting_input <= 1'b0;
            state          <= S_FAIL;
          end else begin
            timer <= timer - TMR_W'(1);
          end
`endif
        end

        S_WIN, S_FAIL: begin
          if (start) begin
            len   <= '0;
            idx   <= '0;
            win   <= 1'b0;
            fail  <= 1'b0;
            timer <= '0;
            state <= S_ADD;
          end
        end

        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_memgame_ctrl.sv
// Testbench for memgame_ctrl with a small configuration (3 rounds, short
// display/gap times). Expected display elements are queued as each round is
// started and checked by a monitor when the DUT shows them.
module tb_memgame_ctrl;

  localparam int MAX_LEN = 3;
  localparam int SHOW    = 4;
  localparam int GAP     = 2;
  localparam int TMO     = 8;

  logic       clk;
  logic       rst_n;
  logic       start;
  logic [3:0] rnd_in;
  logic       guess_valid;
  logic [3:0] guess;
  logic       show_valid;
  logic [3:0] show_num;
  logic       awaiting_input;
  logic [1:0] level;
  logic       win;
  logic       fail;

  int n_pass  = 0;
  int n_total = 0;

  logic [3:0] exp_q [$];

  memgame_ctrl #(
    .MAX_LEN        (MAX_LEN),
    .SHOW_CYCLES    (SHOW),
    .GAP_CYCLES     (GAP),
    .TIMEOUT_CYCLES (TMO)
  ) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .start          (start),
    .rnd_in         (rnd_in),
    .guess_valid    (guess_valid),
    .guess          (guess),
    .show_valid     (show_valid),
    .show_num       (show_num),
    .awaiting_input (awaiting_input),
    .level          (level),
    .win            (win),
    .fail           (fail)
  );

  // Free-running clock, period 10.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Display monitor: pops an expected element when a show period begins and
  // checks value every cycle plus the period length when it ends.
  logic       prev_show = 1'b0;
  logic       run_ok    = 1'b0;
  int         run_len   = 0;
  logic [3:0] cur_exp   = 4'h0;

  always @(negedge clk) begin
    if (!rst_n) begin
      prev_show = 1'b0;
      run_len   = 0;
      run_ok    = 1'b0;
    end else begin
      if (show_valid && !prev_show) begin
        n_total++;
        if (exp_q.size() == 0) begin
          $display("[TB] FAIL show_pop: show_num=%h appeared, required no display (queue empty)", show_num);
          run_ok = 1'b0;
        end else begin
          n_pass++;
          cur_exp = exp_q.pop_front();
          run_ok  = 1'b1;
        end
        run_len = 0;
      end
      if (show_valid) begin
        run_len++;
        if (run_ok) begin
          n_total++;
          if (show_num !== cur_exp)
            $display("[TB] FAIL show_num: got %h, required %h", show_num, cur_exp);
          else
            n_pass++;
        end
      end
      if (!show_valid && prev_show) begin
        n_total++;
        if (run_len != SHOW || show_num !== 4'h0)
          $display("[TB] FAIL show_len: got %0d cycles (num %h), required %0d cycles (num 0)", run_len, show_num, SHOW);
        else
          n_pass++;
      end
      prev_show = show_valid;
    end
  end

  task automatic start_game(input logic [3:0] v);
    @(negedge clk);
    start  = 1'b1;
    rnd_in = v;
    @(negedge clk);
    start  = 1'b0;
  endtask

  // Drives one guess at the current negedge; returns at the negedge of the result cycle.
  task automatic drive_guess(input logic [3:0] g, input logic [3:0] nxt);
    guess_valid = 1'b1;
    guess       = g;
    rnd_in      = nxt;
    @(negedge clk);
    guess_valid = 1'b0;
  endtask

  task automatic wait_for_input(input int budget);
    bit seen = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (awaiting_input) begin
        seen = 1'b1;
        break;
      end
    end
    n_total++;
    if (!seen) $display("[TB] FAIL wait_input: awaiting_input=%b after %0d cycles, required 1", awaiting_input, budget);
    else n_pass++;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    #1;
    n_total++;
    if ({show_valid, show_num, awaiting_input, level, win, fail} !== 10'b0)
      $display("[TB] FAIL reset_outputs: got %b, required 0", {show_valid, show_num, awaiting_input, level, win, fail});
    else n_pass++;
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      n_total++;
      if ({show_valid, show_num, awaiting_input, level, win, fail} !== 10'b0)
        $display("[TB] FAIL idle_outputs: cycle %0d got %b, required 0", i, {show_valid, show_num, awaiting_input, level, win, fail});
      else n_pass++;
    end
  endtask

  task automatic test_first_round();
    int k;
    exp_q.push_back(4'hA);
    start_game(4'hA);
    n_total++;
    if (show_valid !== 1'b0 || level !== 2'd0)
      $display("[TB] FAIL add_cycle: show_valid=%b level=%0d, required 0/0", show_valid, level);
    else n_pass++;
    @(negedge clk);
    n_total++;
    if (show_valid !== 1'b1 || level !== 2'd1)
      $display("[TB] FAIL show_rise: show_valid=%b level=%0d, required 1/1", show_valid, level);
    else n_pass++;
    k = 0;
    for (int i = 1; i <= 20; i++) begin
      @(negedge clk);
      if (awaiting_input) begin
        k = i;
        break;
      end
    end
    n_total++;
    if (k != SHOW + GAP)
      $display("[TB] FAIL input_latency: got %0d cycles, required %0d", k, SHOW + GAP);
    else n_pass++;
    exp_q.push_back(4'hA);
    exp_q.push_back(4'h5);
    drive_guess(4'hA, 4'h5);
    n_total++;
    if (awaiting_input !== 1'b0 || level !== 2'd1)
      $display("[TB] FAIL final_guess: awaiting=%b level=%0d, required 0/1", awaiting_input, level);
    else n_pass++;
    @(negedge clk);
    n_total++;
    if (level !== 2'd2 || show_valid !== 1'b1)
      $display("[TB] FAIL round2: level=%0d show_valid=%b, required 2/1", level, show_valid);
    else n_pass++;
  endtask

  task automatic test_wrong_entry();
    wait_for_input(40);
    drive_guess(4'hA, 4'h0);
    n_total++;
    if (awaiting_input !== 1'b1 || fail !== 1'b0)
      $display("[TB] FAIL partial_guess: awaiting=%b fail=%b, required 1/0", awaiting_input, fail);
    else n_pass++;
    drive_guess(4'h3, 4'h0);
    n_total++;
    if (fail !== 1'b1 || awaiting_input !== 1'b0 || level !== 2'd2)
      $display("[TB] FAIL wrong_guess: fail=%b awaiting=%b level=%0d, required 1/0/2", fail, awaiting_input, level);
    else n_pass++;
    @(negedge clk);
    drive_guess(4'h3, 4'h0);
    @(negedge clk);
    n_total++;
    if (fail !== 1'b1 || level !== 2'd2 || show_valid !== 1'b0)
      $display("[TB] FAIL fail_hold: fail=%b level=%0d show=%b, required 1/2/0", fail, level, show_valid);
    else n_pass++;
    exp_q.push_back(4'h7);
    start_game(4'h7);
    n_total++;
    if (fail !== 1'b0 || level !== 2'd0)
      $display("[TB] FAIL restart_clear: fail=%b level=%0d, required 0/0", fail, level);
    else n_pass++;
    @(negedge clk);
    n_total++;
    if (level !== 2'd1 || show_num !== 4'h7)
      $display("[TB] FAIL restart_show: level=%0d show_num=%h, required 1/7", level, show_num);
    else n_pass++;
  endtask

  task automatic test_full_win();
    wait_for_input(40);
    exp_q.push_back(4'h7);
    exp_q.push_back(4'h2);
    drive_guess(4'h7, 4'h2);
    wait_for_input(60);
    exp_q.push_back(4'h7);
    exp_q.push_back(4'h2);
    exp_q.push_back(4'h9);
    drive_guess(4'h7, 4'h0);
    drive_guess(4'h2, 4'h9);
    wait_for_input(80);
    drive_guess(4'h7, 4'h0);
    drive_guess(4'h2, 4'h0);
    drive_guess(4'h9, 4'h0);
    n_total++;
    if (win !== 1'b1 || level !== 2'd3 || awaiting_input !== 1'b0)
      $display("[TB] FAIL win_set: win=%b level=%0d awaiting=%b, required 1/3/0", win, level, awaiting_input);
    else n_pass++;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      drive_guess(4'h9, 4'h0);
    end
    n_total++;
    if (win !== 1'b1 || level !== 2'd3 || show_valid !== 1'b0 || fail !== 1'b0)
      $display("[TB] FAIL win_hold: win=%b level=%0d show=%b fail=%b, required 1/3/0/0", win, level, show_valid, fail);
    else n_pass++;
    exp_q.push_back(4'hC);
    start_game(4'hC);
    n_total++;
    if (win !== 1'b0 || level !== 2'd0)
      $display("[TB] FAIL win_restart: win=%b level=%0d, required 0/0", win, level);
    else n_pass++;
  endtask

  task automatic test_reset_mid();
    @(negedge clk);
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    n_total++;
    if (show_valid !== 1'b0 || level !== 2'd0 || show_num !== 4'h0 || win !== 1'b0)
      $display("[TB] FAIL reset_mid: show=%b level=%0d num=%h win=%b, required 0/0/0/0", show_valid, level, show_num, win);
    else n_pass++;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      n_total++;
      if ({show_valid, awaiting_input, level, win, fail} !== 6'b0)
        $display("[TB] FAIL post_reset_idle: cycle %0d got %b, required 0", i, {show_valid, awaiting_input, level, win, fail});
      else n_pass++;
    end
  endtask

  task automatic test_timeout();
    int cnt;
    exp_q.push_back(4'h1);
    start_game(4'h1);
    wait_for_input(40);
`ifdef MEMGAME_TIMEOUT_EN
    cnt = 1;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (!awaiting_input) break;
      cnt++;
    end
    n_total++;
    if (cnt != TMO || fail !== 1'b1)
      $display("[TB] FAIL timeout: %0d input cycles fail=%b, required %0d/1", cnt, fail, TMO);
    else n_pass++;
`else
    cnt = 0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (awaiting_input && !fail) cnt++;
    end
    n_total++;
    if (cnt != 100)
      $display("[TB] FAIL no_timeout: awaiting held %0d cycles, required 100", cnt);
    else n_pass++;
    exp_q.push_back(4'h1);
    exp_q.push_back(4'h6);
    start = 1'b1;
    drive_guess(4'h1, 4'h6);
    start = 1'b0;
    @(negedge clk);
    n_total++;
    if (level !== 2'd2 || fail !== 1'b0)
      $display("[TB] FAIL start_with_guess: level=%0d fail=%b, required 2/0", level, fail);
    else n_pass++;
    wait_for_input(60);
`endif
  endtask

  initial begin
    start       = 1'b0;
    rnd_in      = 4'h0;
    guess_valid = 1'b0;
    guess       = 4'h0;
    test_reset();
    test_first_round();
    test_wrong_entry();
    test_full_win();
    test_reset_mid();
    test_timeout();
    n_total++;
    if (exp_q.size() != 0)
      $display("[TB] FAIL display_drain: %0d elements never shown, required 0", exp_q.size());
    else n_pass++;
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
